// File: rtl/restoring_divider_32.sv
// restoring_divider_32: 32-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshake.
// Optional signed support is enabled by defining DIV_SIGNED_EN.
`default_nettype none

module restoring_divider_32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        ready,
    output logic        busy,
    output logic [31:0] c,
    output logic        valid,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic        sel_rem_q, sel_rem_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        fast_q, fast_d;
    logic [31:0] fres_q, fres_d;
    logic [31:0] c_q, c_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic        w_accept;
    logic        w_is_signed;
    logic        w_ovf;
    logic        w_div0;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_diff, w_rem_next;
    logic        w_ge;
    logic [31:0] w_quo_next, w_quo_res, w_rem_res, w_res;
    logic        w_unused_bits;

`ifdef DIV_SIGNED_EN
    assign w_is_signed   = ~op[0];
    assign w_ovf         = w_is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_unused_bits = rem_q[32];
`else
    assign w_is_signed   = 1'b0;
    assign w_ovf         = 1'b0;
    assign w_unused_bits = rem_q[32] ^ op[0];
`endif

    assign w_accept = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && ready));
    assign w_div0   = (b == 32'd0);
    assign w_a_neg  = w_is_signed & a[31];
    assign w_b_neg  = w_is_signed & b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;

    // The restored remainder is always below the divisor, so bit 32 is never needed in the shift.
    assign w_shift    = {rem_q[31:0], quo_q[31]};
    assign w_diff     = w_shift - {1'b0, div_q};
    assign w_ge       = ~w_diff[32];
    assign w_rem_next = w_ge ? w_diff : w_shift;
    assign w_quo_next = {quo_q[30:0], w_ge};

    assign w_quo_res = qneg_q ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_rem_res = rneg_q ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];
    assign w_res     = sel_rem_q ? w_rem_res : w_quo_res;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        sel_rem_d = sel_rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        fast_d    = fast_q;
        fres_d    = fres_q;
        c_d       = c_q;
        valid_d   = valid_q;
        done_d    = 1'b0;

        case (state_q)
            S_CALC: begin
                if (fast_q) begin
                    state_d = S_DONE;
                    cnt_d   = 6'd0;
                    c_d     = fres_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    rem_d = w_rem_next;
                    quo_d = w_quo_next;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = S_DONE;
                        c_d     = w_res;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Acceptance overrides the per-state defaults, covering both IDLE and back-to-back DONE.
        if (w_accept) begin
            state_d   = S_CALC;
            cnt_d     = 6'd32;
            rem_d     = 33'd0;
            quo_d     = w_a_mag;
            div_d     = w_b_mag;
            sel_rem_d = op[1];
            qneg_d    = w_a_neg ^ w_b_neg;
            rneg_d    = w_a_neg;
            fast_d    = w_div0 | w_ovf;
            if (w_div0) begin
                fres_d = op[1] ? a : 32'hFFFF_FFFF;
            end else begin
                fres_d = op[1] ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            sel_rem_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            fast_q    <= 1'b0;
            fres_q    <= 32'd0;
            c_q       <= 32'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            sel_rem_q <= sel_rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            fast_q    <= fast_d;
            fres_q    <= fres_d;
            c_q       <= c_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign c     = c_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_32.sv
// tb_restoring_divider_32: table-driven directed checks plus handshake, backpressure and reset sequences.
`default_nettype none

module tb_restoring_divider_32;

    logic        clk;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        start;
    logic        ready;
    logic        busy;
    logic [31:0] c;
    logic        valid;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    restoring_divider_32 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .op      (op),
        .start   (start),
        .ready   (ready),
        .busy    (busy),
        .c       (c),
        .valid   (valid),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and wait for valid; lat counts edges after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [31:0] res, output logic d);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40 && !valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = c;
        d   = done;
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check({name, "_valid_clr"}, {31'd0, valid}, 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic [31:0] held;
        logic        d;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         32});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          32});
        vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{2'b01, 32'd1000,       32'd10,         32'd100,        32});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'd10,         32'd5,          32});
        vecs.push_back('{2'b01, 32'd3,          32'd7,          32'd0,          32});
        vecs.push_back('{2'b11, 32'd3,          32'd7,          32'd3,          32});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
`else
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'd1,          32});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32});
`endif

        reset_n = 1'b0; a = '0; b = '0; op = '0; start = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_c",     c,              32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, d);
            check($sformatf("vec%0d_c", i),    res,         vecs[i].exp_c);
            check($sformatf("vec%0d_lat", i),  lat,         vecs[i].exp_lat);
            check($sformatf("vec%0d_done", i), {31'd0, d},  32'd1);
            consume($sformatf("vec%0d", i));
        end

        // Start pulse during CALC must be ignored; then hold ready low for 5 cycles.
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1; ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40 && !valid) begin
            @(negedge clk);
            if (lat == 5) begin
                start = 1'b1; a = 32'd9; b = 32'd3; op = 2'b11;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check("bp_lat",  lat, 32);
        check("bp_c",    c,   32'd14);
        check("bp_done", {31'd0, done}, 32'd1);
        held = c;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_c", k),     c,              held);
            check($sformatf("bp_hold%0d_valid", k), {31'd0, valid}, 32'd1);
            check($sformatf("bp_hold%0d_done", k),  {31'd0, done},  32'd0);
        end

        // Back-to-back: ready and start together in DONE.
        @(negedge clk);
        ready = 1'b1; start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
        @(posedge clk);
        #1;
        ready = 1'b0; start = 1'b0;
        check("b2b_valid_clr", {31'd0, valid}, 32'd0);
        check("b2b_busy",      {31'd0, busy},  32'd1);
        check("b2b_c_held",    c,              32'd14);
        lat = 0;
        while (lat < 40 && !valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat",  lat, 32);
        check("b2b_c",    c,   32'd100);
        check("b2b_done", {31'd0, done}, 32'd1);
        consume("b2b");

        // Asynchronous reset at iteration 10 of a new operation.
        @(negedge clk);
        op = 2'b01; a = 32'd77; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy},  32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_done",  {31'd0, done},  32'd0);
        check("arst_c",     c,              32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'b01, 32'd1000, 32'd10, lat, res, d);
        check("post_rst_c",   res, 32'd100);
        check("post_rst_lat", lat, 32);
        consume("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/restoring_divider_32.md
RESTORING_DIVIDER_32 -- requirements
Module: restoring_divider_32

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port a  input  32  dividend.
REQ-004 SHALL have port b  input  32  divisor.
REQ-005 SHALL have port op  input  2  operation: op[1]=1 remainder / 0 quotient; op[0]=1 unsigned / 0 signed (00 DIV, 01 DIVU, 10 REM, 11 REMU).
REQ-006 SHALL have port start  input  1  request; a, b and op sampled on acceptance.
REQ-007 SHALL have port ready  input  1  consumer accepts result.
REQ-008 SHALL have port busy  output  1  high in CALC and DONE.
REQ-009 SHALL have port c  output  32  result, held stable while valid=1.
REQ-010 SHALL have port valid  output  1  result available, held until consumed.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the edge that sets valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 Acceptance SHALL occur on a rising edge where start=1 and either state=IDLE, or state=DONE with ready=1.
REQ-014 start in CALC, or in DONE with ready=0, SHALL be ignored with no state change.
REQ-015 On acceptance the block SHALL latch the operands and op, load a 6-bit counter with 32, clear the remainder register, and enter CALC.
REQ-016 Each CALC edge SHALL perform one restoring iteration and decrement the counter. An iteration is: shift {rem, quotient} left 1; trial-subtract the divisor; keep the difference and set the quotient LSB if it is non-negative.
REQ-017 The 32nd iteration edge SHALL enter DONE, set valid=1, pulse done, and drive c. Latency is 32 edges from acceptance to valid.
REQ-018 Divide by zero (b=0) SHALL take a fast path: DONE one edge after acceptance.
  - quotient result = 0xFFFFFFFF.
  - remainder result = a.
REQ-019 In DONE with ready=1 and no new acceptance, the block SHALL return to IDLE and clear valid on that edge.
REQ-020 Back-to-back operation: in DONE with ready=1 and start=1, the block SHALL clear valid and enter CALC with the new operands on the same edge.
REQ-021 The done pulse SHALL last exactly one cycle regardless of ready.
REQ-022 c SHALL retain its last value outside DONE and SHALL change only on the edge that asserts valid.
REQ-023 Unsigned arithmetic SHALL be 32-bit, with the remainder register 33 bits wide to hold the trial difference.

Reset
REQ-024 reset_n low SHALL immediately and asynchronously force the following, aborting any operation in progress:
  - state=IDLE;
  - counter, c, valid, done and busy = 0;
  - internal registers = 0.
REQ-025 After reset_n deasserts, the first accepted operation SHALL complete normally; no state from the aborted operation may carry over.

Configuration
REQ-026 Macro DIV_SIGNED_EN SHALL control signed support.
REQ-027 With DIV_SIGNED_EN defined, signed ops SHALL behave as follows:
  - operands are converted to magnitudes at acceptance;
  - the quotient is negated if the operand signs differ;
  - the remainder takes the sign of a.
REQ-028 With DIV_SIGNED_EN defined, signed overflow (a=0x80000000, b=0xFFFFFFFF, op[0]=0) SHALL take the one-edge fast path.
  - quotient result = 0x80000000.
  - remainder result = 0.
REQ-029 Without DIV_SIGNED_EN, op[0] SHALL be ignored, all ops SHALL be treated as unsigned, and the overflow fast path SHALL NOT exist.

Verification
REQ-030 DIVU a=100, b=7, start pulse -> valid and done exactly 32 cycles later, c=14; REMU with the same operands -> c=2.
REQ-031 (DIV_SIGNED_EN) DIV a=0xFFFFFFF9, b=2 -> c=0xFFFFFFFD; REM -> c=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> c=0x80000000 after 1 cycle.
REQ-032 DIVU a=5, b=0 -> c=0xFFFFFFFF with valid 1 cycle after acceptance; REMU -> c=5.
REQ-033 Backpressure: ready=0 for 5 cycles after valid -> c and valid stable and done high for 1 cycle only; start pulses during CALC are ignored; ready=1 together with start=1 in DONE -> new result exactly 32 cycles later.
REQ-034 reset_n low at iteration 10 -> busy, valid, done and c all 0 immediately; after release, DIVU 1000/10 -> c=100.
